led_pwm_peripheral: RTL and testbench
=====================================

Name: led_pwm_peripheral

Overview:
Memory-mapped LED controller, parametrised successor of the single-register LED port. Drives NUM_LEDS outputs, each independently in static mode (driven from an output register) or PWM mode (brightness from a per-channel duty register). A shared programmable prescaler and a free-running PWM counter generate the duty cycle. Sits on the processor's simple rd/wr peripheral bus alongside the other FPGA peripherals.

Parameters:
NUM_LEDS, 8, number of LED channels (1..8)
PWM_BITS, 8, PWM counter and duty width (1..16); PWM period = 2^PWM_BITS ticks
PRESC_BITS, 16, prescaler reload width (1..32)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous and active-low
rd_en_i  input  1  bus read strobe
wr_en_i  input  1  bus write strobe
addr_i  input  32  byte address; only addr_i[7:2] decoded
data_i  input  32  write data
data_o  output  32  read data, combinational
leds_o  output  NUM_LEDS  LED drive, registered

Behaviour:
- Reset: sampled only on posedge clk while rst_n=0. Clears OUT, MODE, all DUTY, PRESCALE, prescaler count, PWM count and leds_o to 0; CTRL.EN resets to 1. Reset mid-PWM-period aborts immediately; leds_o=0 on the first edge with rst_n=0.
- Register map (word offsets; addr_i[1:0] and addr_i[31:8] ignored, so upper addresses alias):
  0x00 OUT rw [NUM_LEDS-1:0] static LED values
  0x04 MODE rw [NUM_LEDS-1:0] per channel: 0 static, 1 PWM
  0x08 PRESCALE rw [PRESC_BITS-1:0] tick every PRESCALE+1 clocks
  0x0C CTRL rw bit0 EN
  0x10 PWM_CNT ro current PWM counter
  0x14 LED_STATE ro current leds_o
  0x20+4*i DUTY_i rw [PWM_BITS-1:0], i < NUM_LEDS
- Unmapped offsets and DUTY_i with i >= NUM_LEDS: reads return 0, writes ignored. Writes to ro registers are ignored. Unused upper bits read as 0; upper bits of data_i are discarded on write.
- Read: data_o = selected register when rd_en_i=1, else 32'h0. Purely combinational, zero wait states.
- Write: takes effect on the posedge where wr_en_i=1. Simultaneous rd and wr to the same register: data_o shows the old value in that cycle.
- Prescaler: while EN=1, presc_cnt increments each clock. When presc_cnt == PRESCALE, a one-clock tick is generated and presc_cnt returns to 0. PRESCALE=0 gives a tick every clock. Any write to PRESCALE clears presc_cnt to 0 on the same edge.
- PWM counter: increments on each tick and wraps from 2^PWM_BITS-1 to 0. No saturation.
- Channel i level: MODE[i]=0 gives OUT[i]. MODE[i]=1 gives (pwm_cnt < DUTY_i). DUTY=0 is always off; DUTY=2^PWM_BITS-1 is on for all but one count of each period (no 100%; use static mode for that).
- leds_o is registered from the current register and counter state. A write on edge N is visible on leds_o at edge N+1 (one-cycle latency).
- EN=0: presc_cnt and pwm_cnt are held at 0 and leds_o is forced to 0; register writes are still accepted. Setting EN=1 resumes counting from 0.
- Mode switch mid-period takes effect at the next edge. The counter is not reset.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks after random writes -> leds_o=0; reads of 0x00/0x04/0x08 return 0; 0x0C reads 1; rst_n asserted with no clk edge -> state unchanged (synchronous).
- Static: write OUT=0xA5, MODE=0 -> leds_o=0xA5 exactly one edge after the write edge; read 0x00 -> 0x000000A5; read 0x14 -> 0xA5; write data_i=0xFFFF_FF3C -> leds_o=0x3C.
- PWM: PRESCALE=3, DUTY_0=64, MODE=0x01, PWM_BITS=8 -> leds_o[0] high for 256 of every 1024 clocks; PWM_CNT increments every 4 clocks and wraps 255->0; DUTY_0=0 gives constant low; DUTY_0=255 gives low only while count=255.
- Prescaler rewrite: PRESCALE=9, then write PRESCALE=1 mid-count -> next tick exactly 2 clocks after the write edge.
- Decode/boundary: read 0x18 and 0x40 -> 0; write to 0x10 -> no effect; access 0x104 aliases 0x04; simultaneous rd+wr to 0x00 -> old value on data_o, new value on the next cycle.
- Enable: EN=0 during active PWM -> leds_o=0 next edge and PWM_CNT reads 0; EN=1 -> counting restarts from 0.

Source files
------------

// File: rtl/led_pwm_peripheral.sv
// Memory-mapped LED controller: per-channel static or PWM drive on the rd/wr peripheral bus.
// A shared prescaler paces a free-running PWM counter compared against per-channel duty registers.
module led_pwm_peripheral #(
    parameter int NUM_LEDS   = 8,
    parameter int PWM_BITS   = 8,
    parameter int PRESC_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en_i,
    input  logic                wr_en_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o,
    output logic [NUM_LEDS-1:0] leds_o
);

    localparam logic [5:0] A_OUT   = 6'h00;
    localparam logic [5:0] A_MODE  = 6'h01;
    localparam logic [5:0] A_PRESC = 6'h02;
    localparam logic [5:0] A_CTRL  = 6'h03;
    localparam logic [5:0] A_PWM   = 6'h04;
    localparam logic [5:0] A_LED   = 6'h05;
    localparam logic [5:0] A_DUTY0 = 6'h08;

    localparam logic [PRESC_BITS-1:0] PRESC_ONE = 1;
    localparam logic [PWM_BITS-1:0]   PWM_ONE   = 1;

    logic [5:0]            word;
    logic [NUM_LEDS-1:0]   out_r;
    logic [NUM_LEDS-1:0]   mode_r;
    logic [PRESC_BITS-1:0] prescale_r;
    logic                  en_r;
    logic [PWM_BITS-1:0]   duty_r [NUM_LEDS];
    logic [PRESC_BITS-1:0] presc_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  presc_wr;
    logic                  tick;
    logic [NUM_LEDS-1:0]   level_p0;
    logic [NUM_LEDS-1:0]   leds_p1;
    logic [31:0]           rdata;
    logic                  unused_bits;

    assign word        = addr_i[7:2];
    assign unused_bits = ^{addr_i[31:8], addr_i[1:0], data_i};

    assign presc_wr = wr_en_i && (word == A_PRESC);
    // A PRESCALE write restarts the prescale interval, so it wins over a coincident tick.
    assign tick     = en_r && (presc_cnt == prescale_r) && !presc_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_r      <= '0;
            mode_r     <= '0;
            prescale_r <= '0;
            en_r       <= 1'b1;
            for (int i = 0; i < NUM_LEDS; i++) begin
                duty_r[i] <= '0;
            end
        end else if (wr_en_i) begin
            case (word)
                A_OUT:   out_r      <= data_i[NUM_LEDS-1:0];
                A_MODE:  mode_r     <= data_i[NUM_LEDS-1:0];
                A_PRESC: prescale_r <= data_i[PRESC_BITS-1:0];
                A_CTRL:  en_r       <= data_i[0];
                default: ;
            endcase
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (word == A_DUTY0 + 6'(i)) begin
                    duty_r[i] <= data_i[PWM_BITS-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (!en_r) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            if (presc_wr || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_ONE;
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + PWM_ONE;
            end
        end
    end

    // Stage p0: per-channel level from current registers and counter
    always_comb begin
        level_p0 = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            level_p0[i] = mode_r[i] ? (pwm_cnt < duty_r[i]) : out_r[i];
        end
    end

    // Stage p1: registered LED drive, blanked while disabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leds_p1 <= '0;
        end else begin
            leds_p1 <= en_r ? level_p0 : '0;
        end
    end

    assign leds_o = leds_p1;

    always_comb begin
        rdata = '0;
        case (word)
            A_OUT:   rdata[NUM_LEDS-1:0]   = out_r;
            A_MODE:  rdata[NUM_LEDS-1:0]   = mode_r;
            A_PRESC: rdata[PRESC_BITS-1:0] = prescale_r;
            A_CTRL:  rdata[0]              = en_r;
            A_PWM:   rdata[PWM_BITS-1:0]   = pwm_cnt;
            A_LED:   rdata[NUM_LEDS-1:0]   = leds_p1;
            default: ;
        endcase
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (word == A_DUTY0 + 6'(i)) begin
                rdata[PWM_BITS-1:0] = duty_r[i];
            end
        end
    end

    assign data_o = rd_en_i ? rdata : 32'h0;

endmodule

// File: tb/tb_led_pwm_peripheral.sv
// Scoreboard bench for led_pwm_peripheral: expectations queued at stimulus, popped at observation.
module tb_led_pwm_peripheral;

    localparam int NUM_LEDS   = 8;
    localparam int PWM_BITS   = 8;
    localparam int PRESC_BITS = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                rd_en_i;
    logic                wr_en_i;
    logic [31:0]         addr_i;
    logic [31:0]         data_i;
    logic [31:0]         data_o;
    logic [NUM_LEDS-1:0] leds_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    led_pwm_peripheral #(
        .NUM_LEDS(NUM_LEDS),
        .PWM_BITS(PWM_BITS),
        .PRESC_BITS(PRESC_BITS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rd_en_i(rd_en_i),
        .wr_en_i(wr_en_i),
        .addr_i(addr_i),
        .data_i(data_i),
        .data_o(data_o),
        .leds_o(leds_o)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            check_val(tag_q.pop_front(), act, exp_q.pop_front());
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr_i  = a;
        data_i  = d;
        wr_en_i = 1'b1;
        @(posedge clk);
        #1;
        wr_en_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr_i  = a;
        rd_en_i = 1'b1;
        @(negedge clk);
        d = data_o;
        @(posedge clk);
        #1;
        rd_en_i = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] d;
        sb_push(tag, e);
        bus_read(a, d);
        sb_pop(d);
    endtask

    task automatic leds_chk(input string tag, input logic [7:0] e);
        sb_push(tag, 32'(e));
        sb_pop(32'(leds_o));
    endtask

    task automatic count_high(input string tag, input int n, input int e);
        int hi;
        hi = 0;
        sb_push(tag, 32'(e));
        for (int i = 0; i < n; i++) begin
            cycles(1);
            hi += int'(leds_o[0]);
        end
        sb_pop(32'(hi));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [31:0] v0;
        int          found;

        rst_n   = 1'b0;
        rd_en_i = 1'b0;
        wr_en_i = 1'b0;
        addr_i  = '0;
        data_i  = '0;
        cycles(2);
        leds_chk("rst_leds", 8'h00);
        read_chk("rst_ctrl", 32'h0C, 32'h1);
        rst_n = 1'b1;

        // Dirty the registers, then reset again
        bus_write(32'h00, $urandom);
        bus_write(32'h04, $urandom);
        bus_write(32'h08, $urandom | 32'h1);
        bus_write(32'h20, $urandom);
        cycles(2);
        rst_n = 1'b0;
        cycles(2);
        leds_chk("rst2_leds", 8'h00);
        read_chk("rst2_out", 32'h00, 32'h0);
        read_chk("rst2_mode", 32'h04, 32'h0);
        read_chk("rst2_presc", 32'h08, 32'h0);
        read_chk("rst2_ctrl", 32'h0C, 32'h1);
        read_chk("rst2_duty0", 32'h20, 32'h0);
        read_chk("rst2_pwmcnt", 32'h10, 32'h0);
        rst_n = 1'b1;

        // Reset takes effect only at a clock edge
        bus_write(32'h00, 32'h5A);
        cycles(1);
        leds_chk("pre_rst_leds", 8'h5A);
        rst_n   = 1'b0;
        addr_i  = 32'h00;
        rd_en_i = 1'b1;
        #2;
        sb_push("norst_edge_out", 32'h5A);
        sb_pop(data_o);
        leds_chk("norst_edge_leds", 8'h5A);
        @(posedge clk);
        #1;
        rd_en_i = 1'b0;
        leds_chk("sync_rst_leds", 8'h00);
        rst_n = 1'b1;
        read_chk("sync_rst_out", 32'h00, 32'h0);

        // Static mode and one-cycle write-to-LED latency
        bus_write(32'h04, 32'h0);
        bus_write(32'h00, 32'hA5);
        leds_chk("static_lat0", 8'h00);
        cycles(1);
        leds_chk("static_lat1", 8'hA5);
        read_chk("static_out", 32'h00, 32'hA5);
        read_chk("static_ledstate", 32'h14, 32'hA5);
        bus_write(32'h00, 32'hFFFF_FF3C);
        cycles(1);
        leds_chk("static_trunc_leds", 8'h3C);
        read_chk("static_trunc_out", 32'h00, 32'h3C);

        // Decode, aliasing, simultaneous read/write
        read_chk("unmapped_18", 32'h18, 32'h0);
        read_chk("unmapped_40", 32'h40, 32'h0);
        read_chk("unmapped_1c", 32'h1C, 32'h0);
        bus_write(32'h104, 32'h3);
        read_chk("alias_mode", 32'h04, 32'h3);
        read_chk("alias_lowbits", 32'h107, 32'h3);
        bus_write(32'h04, 32'h0);
        addr_i  = 32'h00;
        data_i  = 32'h77;
        rd_en_i = 1'b1;
        wr_en_i = 1'b1;
        @(negedge clk);
        sb_push("rdwr_old", 32'h3C);
        sb_pop(data_o);
        @(posedge clk);
        #1;
        rd_en_i = 1'b0;
        wr_en_i = 1'b0;
        read_chk("rdwr_new", 32'h00, 32'h77);

        // PWM: 4-clock tick, 256-count period
        bus_write(32'h08, 32'd3);
        bus_write(32'h20, 32'd64);
        bus_write(32'h04, 32'h01);
        cycles(2);
        count_high("pwm_duty64", 1024, 256);
        read_chk("duty0_rb", 32'h20, 32'd64);

        bus_read(32'h10, v0);
        found = 0;
        v     = v0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            bus_read(32'h10, v);
            if (v != v0) found = 1;
        end
        check_val("pwm_step_seen", 32'(found), 32'd1);
        check_val("pwm_step_plus1", v, (v0 + 32'd1) & 32'hFF);
        for (int i = 0; i < 3; i++) begin
            read_chk("pwm_hold", 32'h10, v);
        end
        read_chk("pwm_next", 32'h10, (v + 32'd1) & 32'hFF);

        found = 0;
        for (int i = 0; i < 1100 && found == 0; i++) begin
            bus_read(32'h10, v);
            if (v == 32'd255) found = 1;
        end
        check_val("pwm_reach_255", 32'(found), 32'd1);
        for (int i = 0; i < 8 && v == 32'd255; i++) begin
            bus_read(32'h10, v);
        end
        check_val("pwm_wrap", v, 32'd0);

        bus_write(32'h20, 32'd0);
        cycles(2);
        count_high("pwm_duty0", 1024, 0);
        bus_write(32'h20, 32'd255);
        cycles(2);
        count_high("pwm_duty255", 1024, 1020);

        // PRESCALE rewrite restarts the interval
        bus_write(32'h08, 32'd9);
        bus_read(32'h10, v);
        read_chk("presc_pre", 32'h10, v);
        bus_write(32'h08, 32'd1);
        read_chk("presc_w1", 32'h10, v);
        read_chk("presc_w2", 32'h10, v);
        read_chk("presc_tick", 32'h10, (v + 32'd1) & 32'hFF);

        // Enable gating
        bus_write(32'h08, 32'd0);
        bus_write(32'h20, 32'd128);
        cycles(3);
        bus_write(32'h0C, 32'h0);
        cycles(1);
        leds_chk("en0_leds", 8'h00);
        read_chk("en0_cnt", 32'h10, 32'h0);
        read_chk("en0_ctrl", 32'h0C, 32'h0);
        bus_write(32'h10, 32'hAB);
        read_chk("ro_write_ignored", 32'h10, 32'h0);
        bus_write(32'h00, 32'hFF);
        read_chk("en0_write_ok", 32'h00, 32'hFF);
        leds_chk("en0_leds_hold", 8'h00);
        bus_write(32'h0C, 32'h1);
        read_chk("en1_cnt0", 32'h10, 32'd0);
        read_chk("en1_cnt1", 32'h10, 32'd1);
        read_chk("en1_cnt2", 32'h10, 32'd2);
        leds_chk("en1_leds", 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
